timer_bank: RTL

TIMER_BANK -- requirements
Module: timer_bank

---
 rtl/timer_bank.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/timer_bank.sv
// Bank of NCH down-counting timers behind a small byte-wide register file.
// A shared 7-bit prescaler provides per-channel divide-by-2^s ticks.
module timer_bank #(
    parameter int NCH = 4,
    parameter int CNT_W = 16,
    localparam int ADDR_W = $clog2(NCH) + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata,
    output logic [NCH-1:0]    irq,
    output logic              irq_any
);

    typedef struct packed {
        logic       irq_en;
        logic [2:0] presc;
        logic       mode;
        logic       enable;
    } ctrl_t;

    ctrl_t            ctrl   [NCH];
    logic [CNT_W-1:0] reload [NCH];
    logic [CNT_W-1:0] count  [NCH];
    logic [NCH-1:0]   pending;
    logic [6:0]       pre;

    logic [ADDR_W-1:0] ch_sel;
    logic [1:0]        reg_sel;
    logic [NCH-1:0]    hit, load, run, expire, clr;
    logic [7:0]        rd_next;

    function automatic logic [6:0] presc_mask(input logic [2:0] s);
        return 7'((8'd1 << s) - 8'd1);
    endfunction

    // Byte view of a counter-width value; the upper byte is zero for 8-bit counters.
    function automatic logic [7:0] cnt_byte(input logic [CNT_W-1:0] v, input logic hi);
        logic [15:0] t;
        t = 16'(v);
        return hi ? t[15:8] : t[7:0];
    endfunction

    // With 8-bit counters the upper-byte write truncates away, leaving v unchanged.
    function automatic logic [CNT_W-1:0] set_byte(input logic [CNT_W-1:0] v, input logic hi,
                                                  input logic [7:0] b);
        logic [15:0] t;
        t = 16'(v);
        if (hi) t[15:8] = b;
        else    t[7:0]  = b;
        return CNT_W'(t);
    endfunction

    assign ch_sel  = addr >> 2;
    assign reg_sel = addr[1:0];

    always_comb begin
        hit    = '0;
        load   = '0;
        run    = '0;
        expire = '0;
        clr    = '0;
        for (int i = 0; i < NCH; i++) begin
            hit[i]    = (ch_sel == ADDR_W'(i));
            load[i]   = we && hit[i] && (reg_sel == 2'd0) && wdata[0] && !ctrl[i].enable;
            run[i]    = ctrl[i].enable && !load[i] && (&(pre | ~presc_mask(ctrl[i].presc)));
            expire[i] = run[i] && (count[i] == '0);
            clr[i]    = we && hit[i] && (reg_sel == 2'd3) && wdata[0];
        end
    end

    // Unmatched channel numbers fall through to zero.
    always_comb begin
        rd_next = 8'h00;
        for (int i = 0; i < NCH; i++) begin
            if (hit[i]) begin
                case (reg_sel)
                    2'd0:    rd_next = {2'b00, ctrl[i]};
                    2'd1:    rd_next = cnt_byte(count[i], 1'b0);
                    2'd2:    rd_next = cnt_byte(count[i], 1'b1);
                    default: rd_next = {7'd0, pending[i]};
                endcase
            end
        end
    end

    always_comb begin
        irq = '0;
        for (int i = 0; i < NCH; i++) begin
            irq[i] = pending[i] & ctrl[i].irq_en;
        end
    end

    assign irq_any = |irq;

    always_ff @(posedge clk) begin
        if (reset) begin
            pre     <= '0;
            rdata   <= '0;
            pending <= '0;
            for (int i = 0; i < NCH; i++) begin
                ctrl[i]   <= '0;
                reload[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            pre   <= pre + 7'd1;
            rdata <= rd_next;
            for (int i = 0; i < NCH; i++) begin
                // A register write to CTRL overrides the one-shot auto-disable.
                if (we && hit[i] && reg_sel == 2'd0)
                    ctrl[i] <= ctrl_t'(wdata[5:0]);
                else if (expire[i] && ctrl[i].mode)
                    ctrl[i].enable <= 1'b0;

                if (we && hit[i] && reg_sel == 2'd1)
                    reload[i] <= set_byte(reload[i], 1'b0, wdata);
                else if (we && hit[i] && reg_sel == 2'd2)
                    reload[i] <= set_byte(reload[i], 1'b1, wdata);

                if (load[i]) begin
                    count[i] <= reload[i];
                end else if (run[i]) begin
                    if (count[i] != '0)
                        count[i] <= count[i] - CNT_W'(1);
                    else if (!ctrl[i].mode)
                        count[i] <= reload[i];
                end

                if (expire[i])
                    pending[i] <= 1'b1;
                else if (clr[i])
                    pending[i] <= 1'b0;
            end
        end
    end

endmodule
